// File: rtl/time_set_ctrl.sv
// Time-setting controller for the digital clock.
// Synchronises and debounces the MODE and INC buttons, runs the RUN -> SET_HR -> SET_MIN
// session, auto-repeats a held INC, and hands the edited time to the clock counter as a
// one-cycle load pulse. Also drives the blink enables for the display multiplexer.
module time_set_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_CYCLES   = 50000000,
    parameter int unsigned BLINK_W         = 26
) (
    input  logic       i_clock,
    input  logic       i_rst,
    input  logic       i_btn_mode,
    input  logic       i_btn_inc,
    input  logic [4:0] i_cur_hr,
    input  logic [5:0] i_cur_min,
    output logic [4:0] o_set_hr,
    output logic [5:0] o_set_min,
    output logic       o_load,
    output logic       o_editing,
    output logic       o_blink_hr,
    output logic       o_blink_min
);

    localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StSetHr  = 2'd1,
        StSetMin = 2'd2
    } state_e;

    // Button bit 0 = MODE, bit 1 = INC.
    logic [1:0]         r_sync1;
    logic [1:0]         r_sync2;
    logic [1:0]         r_db;
    logic [1:0]         r_db_prev;
    logic [1:0]         r_press;
    logic [DB_W-1:0]    r_db_cnt [2];
    logic [REP_W-1:0]   r_rep_cnt;
    logic               r_rep;
    logic [BLINK_W-1:0] r_blink_cnt;
    state_e             r_state;
    logic [4:0]         r_set_hr;
    logic [5:0]         r_set_min;
    logic               r_load;
    logic               r_editing;
    logic               w_inc_evt;

    // Two-flop synchronisers for both raw buttons.
    always_ff @(posedge i_clock) begin
        if (i_rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {i_btn_inc, i_btn_mode};
            r_sync2 <= r_sync1;
        end
    end

    // Debounce each button and register a one-cycle pulse on the debounced rising edge.
    always_ff @(posedge i_clock) begin
        if (i_rst) begin
            r_db      <= '0;
            r_db_prev <= '0;
            r_press   <= '0;
            for (int i = 0; i < 2; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                r_db_prev[i] <= r_db[i];
                r_press[i]   <= r_db[i] & ~r_db_prev[i];
                if (r_sync2[i] == r_db[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_MAX) begin
                    r_db[i]     <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Auto-repeat for a held INC while editing; a mode pulse means the state is changing.
    always_ff @(posedge i_clock) begin
        if (i_rst) begin
            r_rep_cnt <= '0;
            r_rep     <= 1'b0;
        end else begin
            r_rep <= 1'b0;
            if (!r_db[1] || (r_state == StRun) || r_press[0]) begin
                r_rep_cnt <= '0;
            end else if (r_rep_cnt == REP_MAX) begin
                r_rep_cnt <= '0;
                r_rep     <= 1'b1;
            end else begin
                r_rep_cnt <= r_rep_cnt + 1'b1;
            end
        end
    end

    // Free-running blink counter; its MSB is the blink phase.
    always_ff @(posedge i_clock) begin
        if (i_rst) begin
            r_blink_cnt <= '0;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    assign w_inc_evt = r_press[1] | r_rep;

    // Session FSM with registered outputs; a mode pulse always beats a coincident inc.
    always_ff @(posedge i_clock) begin
        if (i_rst) begin
            r_state   <= StRun;
            r_set_hr  <= '0;
            r_set_min <= '0;
            r_load    <= 1'b0;
            r_editing <= 1'b0;
        end else begin
            r_load <= 1'b0;
            case (r_state)
                StRun: begin
                    if (r_press[0]) begin
                        r_set_hr  <= i_cur_hr;
                        r_set_min <= i_cur_min;
                        r_state   <= StSetHr;
                        r_editing <= 1'b1;
                    end
                end
                StSetHr: begin
                    if (r_press[0]) begin
                        r_state <= StSetMin;
                    end else if (w_inc_evt) begin
                        r_set_hr <= (r_set_hr == 5'd23) ? 5'd0 : r_set_hr + 5'd1;
                    end
                end
                StSetMin: begin
                    if (r_press[0]) begin
                        r_state   <= StRun;
                        r_load    <= 1'b1;
                        r_editing <= 1'b0;
                    end else if (w_inc_evt) begin
                        r_set_min <= (r_set_min == 6'd59) ? 6'd0 : r_set_min + 6'd1;
                    end
                end
                default: begin
                    r_state   <= StRun;
                    r_editing <= 1'b0;
                end
            endcase
        end
    end

    assign o_set_hr    = r_set_hr;
    assign o_set_min   = r_set_min;
    assign o_load      = r_load;
    assign o_editing   = r_editing;
    assign o_blink_hr  = (r_state == StSetHr) & r_blink_cnt[BLINK_W-1];
    assign o_blink_min = (r_state == StSetMin) & r_blink_cnt[BLINK_W-1];

endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl: a press-level model predicts every visible change of
// {load, editing, set_hr, set_min}; a monitor pops and compares whenever the DUT output moves.
module tb_time_set_ctrl;

    localparam int DEB = 4;
    localparam int REP = 16;
    localparam int GAP = 30;

    typedef struct packed {
        logic       load;
        logic       ed;
        logic [4:0] hr;
        logic [5:0] min;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bm  = 1'b0;
    logic       bi  = 1'b0;
    logic [4:0] cur_hr  = '0;
    logic [5:0] cur_min = '0;
    logic [4:0] set_hr;
    logic [5:0] set_min;
    logic       load, editing, blink_hr, blink_min;

    int   n_cmp  = 0;
    int   n_fail = 0;
    ev_t  exp_q[$];
    bit   mon_en = 1'b0;

    // Press-level reference model: 0 = RUN, 1 = SET_HR, 2 = SET_MIN.
    int   m_state = 0;
    int   m_hr    = 0;
    int   m_min   = 0;
    logic [3:0] m_blink;

    time_set_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_CYCLES  (REP),
        .BLINK_W        (4)
    ) dut (
        .i_clock    (clk),
        .i_rst      (rst),
        .i_btn_mode (bm),
        .i_btn_inc  (bi),
        .i_cur_hr   (cur_hr),
        .i_cur_min  (cur_min),
        .o_set_hr   (set_hr),
        .o_set_min  (set_min),
        .o_load     (load),
        .o_editing  (editing),
        .o_blink_hr (blink_hr),
        .o_blink_min(blink_min)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) m_blink <= '0;
        else     m_blink <= m_blink + 4'd1;
    end

    task automatic check(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    function automatic void push(input bit ld, input bit ed, input int hr, input int mn);
        ev_t e;
        e.load = ld;
        e.ed   = ed;
        e.hr   = 5'(hr);
        e.min  = 6'(mn);
        exp_q.push_back(e);
    endfunction

    // Model one button action: raw buttons held high for h cycles (clean, bounce-free).
    function automatic void model_press(input bit do_mode, input bit do_inc, input int h);
        if (do_mode) begin
            if (m_state == 0) begin
                m_hr    = int'(cur_hr);
                m_min   = int'(cur_min);
                m_state = 1;
                push(1'b0, 1'b1, m_hr, m_min);
            end else if (m_state == 1) begin
                m_state = 2;
            end else begin
                m_state = 0;
                push(1'b1, 1'b0, m_hr, m_min);
                push(1'b0, 1'b0, m_hr, m_min);
            end
        end else if (do_inc && m_state != 0) begin
            // Debounced INC stays high for h cycles: one press step plus one per full REP.
            for (int k = 0; k < 1 + h / REP; k++) begin
                if (m_state == 1) m_hr = (m_hr + 1) % 24;
                else              m_min = (m_min + 1) % 60;
                push(1'b0, 1'b1, m_hr, m_min);
            end
        end
    endfunction

    task automatic press(input bit do_mode, input bit do_inc, input int h);
        model_press(do_mode, do_inc, h);
        @(posedge clk);
        #1;
        bm = do_mode;
        bi = do_inc;
        repeat (h) @(posedge clk);
        #1;
        bm = 1'b0;
        bi = 1'b0;
        repeat (GAP) @(posedge clk);
    endtask

    task automatic blink_check(input string name);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check({name, "_hr"}, int'(blink_hr), (m_state == 1) ? int'(m_blink[3]) : 0);
            check({name, "_min"}, int'(blink_min), (m_state == 2) ? int'(m_blink[3]) : 0);
        end
    endtask

    // Monitor: every change of the observed tuple must match the next scoreboard entry.
    initial begin
        ev_t obs, last, e;
        logic prev_load;
        last      = '0;
        prev_load = 1'b0;
        forever begin
            @(negedge clk);
            obs = {load, editing, set_hr, set_min};
            if (mon_en && obs != last) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_change: got load=%0d ed=%0d hr=%0d min=%0d, expected no change",
                             obs.load, obs.ed, obs.hr, obs.min);
                end else begin
                    e = exp_q.pop_front();
                    if (obs != e) begin
                        n_fail++;
                        $display("FAIL event: got load=%0d ed=%0d hr=%0d min=%0d, expected load=%0d ed=%0d hr=%0d min=%0d",
                                 obs.load, obs.ed, obs.hr, obs.min, e.load, e.ed, e.hr, e.min);
                    end
                end
            end
            if (mon_en && load) begin
                n_cmp++;
                if (prev_load) begin
                    n_fail++;
                    $display("FAIL double_load: got load high 2 cycles, expected 1");
                end
            end
            prev_load = load;
            last      = obs;
        end
    end

    initial begin
        int r, h;

        // Reset with buttons toggling.
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            bm = ~bm;
            bi = ~bi;
        end
        @(negedge clk);
        check("rst_hr", int'(set_hr), 0);
        check("rst_min", int'(set_min), 0);
        check("rst_load", int'(load), 0);
        check("rst_editing", int'(editing), 0);
        check("rst_blink", int'({blink_hr, blink_min}), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bm  = 1'b0;
        bi  = 1'b0;
        repeat (10) @(posedge clk);
        mon_en = 1'b1;

        // Glitch shorter than the debounce window.
        @(posedge clk);
        #1;
        bm = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bm = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("glitch_editing", int'(editing), 0);

        // Debounce latency: 2 sync + 4 debounce + 1 pulse + 1 registered output.
        cur_hr  = 5'd22;
        cur_min = 6'd58;
        model_press(1'b1, 1'b0, 10);
        @(posedge clk);
        #1;
        bm = 1'b1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("deb_editing_early", int'(editing), 0);
        @(posedge clk);
        @(negedge clk);
        check("deb_editing_on", int'(editing), 1);
        check("capture_hr", int'(set_hr), 22);
        check("capture_min", int'(set_min), 58);
        @(posedge clk);
        #1;
        bm = 1'b0;
        repeat (GAP) @(posedge clk);

        // Full session with wrap-around.
        for (int k = 0; k < 3; k++) press(1'b0, 1'b1, 8);
        @(negedge clk);
        check("sess_hr_wrap", int'(set_hr), 1);
        blink_check("blink_sethr");
        press(1'b1, 1'b0, 8);
        for (int k = 0; k < 3; k++) press(1'b0, 1'b1, 8);
        @(negedge clk);
        check("sess_min_wrap", int'(set_min), 1);
        blink_check("blink_setmin");
        press(1'b1, 1'b0, 8);
        @(negedge clk);
        check("sess_editing_off", int'(editing), 0);
        check("sess_load_hr", int'(set_hr), 1);
        check("sess_load_min", int'(set_min), 1);

        // Auto-repeat: hold INC for 1 + 4*REP debounced cycles from set_min = 0.
        cur_hr  = 5'd7;
        cur_min = 6'd0;
        press(1'b1, 1'b0, 8);
        press(1'b1, 1'b0, 8);
        press(1'b0, 1'b1, 1 + 4 * REP);
        @(negedge clk);
        check("repeat_min", int'(set_min), 5);
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("repeat_hold", int'(set_min), 5);
        press(1'b1, 1'b0, 8);

        // Simultaneous mode and inc in SET_HR: mode wins.
        cur_hr  = 5'd13;
        cur_min = 6'd30;
        press(1'b1, 1'b0, 8);
        press(1'b1, 1'b1, 10);
        @(negedge clk);
        check("simul_hr", int'(set_hr), 13);
        press(1'b0, 1'b1, 8);
        @(negedge clk);
        check("simul_in_setmin", int'(set_min), 31);

        // Abort by reset in SET_MIN.
        for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(posedge clk);
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("abort_load", int'(load), 0);
        end
        check("abort_hr", int'(set_hr), 0);
        check("abort_min", int'(set_min), 0);
        check("abort_editing", int'(editing), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_state = 0;
        m_hr    = 0;
        m_min   = 0;
        exp_q.delete();
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("abort_load_after", int'(load), 0);
        mon_en = 1'b1;

        // Randomised button actions against the model.
        for (int n = 0; n < 150; n++) begin
            if (m_state == 0) begin
                cur_hr  = 5'($urandom_range(0, 23));
                cur_min = 6'($urandom_range(0, 59));
            end
            r = int'($urandom_range(0, 9));
            if (r < 4) begin
                press(1'b1, 1'b0, int'($urandom_range(6, 30)));
            end else if (r < 9) begin
                h = REP * int'($urandom_range(0, 3)) + int'($urandom_range(6, 13));
                press(1'b0, 1'b1, h);
            end else begin
                press(1'b1, 1'b1, int'($urandom_range(6, 13)));
            end
        end

        for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(posedge clk);
        check("queue_drain", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- User-input side of the digital clock: turns two raw push-buttons (MODE, INC) into a time-setting session.
- Synchronises and debounces both buttons and walks an RUN → SET_HR → SET_MIN → RUN state machine.
- Edits a local hour/minute copy, with auto-repeat on a held INC button.
- On exit, delivers the new time to the hours/minutes counter as a one-cycle load pulse. It also drives blink-enables for the display multiplexer.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive cycles a synchronised button level must differ from the debounced level before the debounced level flips (10 ms at 100 MHz).
- REPEAT_CYCLES, 50000000: hold time of debounced INC before the first auto-repeat step, and the spacing between later steps.
- BLINK_W, 26: width of the free-running blink counter; its MSB is the blink phase.

Ports:
- clock, in, 1: system clock; all logic on the rising edge.
- rst, in, 1: synchronous reset, active-high.
- btn_mode, in, 1: raw asynchronous MODE button, active-high.
- btn_inc, in, 1: raw asynchronous INC button, active-high.
- cur_hr, in, 5: running hour from the clock counter, 0..23.
- cur_min, in, 6: running minute from the clock counter, 0..59.
- set_hr, out, 5: edited hour, 0..23.
- set_min, out, 6: edited minute, 0..59.
- load, out, 1: one-cycle pulse; the clock counter loads set_hr/set_min and clears its seconds prescaler.
- editing, out, 1: high in SET_HR or SET_MIN; the clock counter freezes while high.
- blink_hr, out, 1: high = blank the hour digits.
- blink_min, out, 1: high = blank the minute digits.

Behaviour:
- **Reset (rst=1 at a clock edge):**
  - state=RUN; set_hr=0, set_min=0; load=0, editing=0, blink_hr=0, blink_min=0.
  - Synchronisers, debounced levels, debounce counters, repeat counter and blink counter all go to 0.
  - Reset mid-edit abandons the session with no load pulse.
- **Synchroniser:** 2-flop per button; all later logic uses only the synchronised level.
- **Debounce (per button):**
  - The counter increments while sync ≠ debounced and clears to 0 whenever sync == debounced.
  - When the counter reaches DEBOUNCE_CYCLES-1 with sync still ≠ debounced, debounced takes sync and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES produces no change.
- **Press pulse:** a registered one-cycle pulse in the cycle after debounced goes 0→1. Release produces no pulse.
- **Auto-repeat (INC only, SET states only):**
  - While debounced INC=1, the repeat counter counts.
  - Each time it reaches REPEAT_CYCLES-1 it emits an extra inc pulse and clears.
  - It clears when INC is released or the state changes.
- **FSM:**
  - RUN: INC ignored. A mode pulse captures cur_hr→set_hr and cur_min→set_min, then moves to SET_HR.
  - SET_HR: an inc pulse sets set_hr = (set_hr==23) ? 0 : set_hr+1. A mode pulse moves to SET_MIN.
  - SET_MIN: an inc pulse sets set_min = (set_min==59) ? 0 : set_min+1. A mode pulse moves to RUN and asserts load for exactly one cycle, registered together with the state change.
- **Simultaneous mode and inc pulse in one cycle:** mode wins and the inc is dropped.
- **Outputs:**
  - editing is registered and equals (state≠RUN).
  - blink_hr = (state==SET_HR) & blink_cnt[BLINK_W-1]; blink_min = (state==SET_MIN) & blink_cnt[BLINK_W-1].
  - set_hr and set_min hold their value in RUN.
  - load is never high in two consecutive cycles.
- **Width rules:** set_hr is never outside 0..23 and set_min never outside 0..59. Captured cur values are trusted to be in range.

Test Plan (bench uses DEBOUNCE_CYCLES=4, REPEAT_CYCLES=16, BLINK_W=4):
- **Reset values:** rst high 3 cycles with buttons toggling → all outputs 0, state RUN, no load.
- **Debounce:**
  - btn_mode high 2 cycles then low → no state change, editing stays 0.
  - btn_mode held 10 cycles → editing=1 exactly 2+4+1 cycles after the first high, plus the registered output cycle.
- **Full session:**
  - cur_hr=22, cur_min=58; MODE press → set_hr=22, set_min=58.
  - 3 INC presses → set_hr=1.
  - MODE, then 3 INC presses → set_min=1.
  - MODE → load=1 for one cycle with set_hr=1, set_min=1; editing=0 afterwards.
- **Auto-repeat:** in SET_MIN from set_min=0, hold INC for 1+4×16 cycles after debounce → set_min=5 (initial press plus 4 repeats); release → no further change.
- **Simultaneity:** in SET_HR, drive MODE and INC so their press pulses coincide → state=SET_MIN, set_hr unchanged.
- **Blink and abort:**
  - In SET_HR, blink_hr toggles with blink_cnt[3] and blink_min stays 0.
  - rst asserted in SET_MIN → state RUN, set_hr=0, set_min=0, and load never pulses.
